// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of the SDRAM memory controller req/ack port
module mem_port_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 8192,
    parameter int TO_W           = 13
) (
    input  logic        clk_in,
    input  logic        rstn,

    input  logic        p0_req,
    input  logic        p0_write,
    input  logic [21:0] p0_addr,
    input  logic [15:0] p0_wdata,
    input  logic        p0_msb,
    input  logic        p0_lsb,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [15:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_write,
    input  logic [21:0] p1_addr,
    input  logic [15:0] p1_wdata,
    input  logic        p1_msb,
    input  logic        p1_lsb,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [15:0] p1_rdata,

    output logic        mc_req,
    output logic        mc_write,
    output logic [21:0] mc_addr,
    output logic [15:0] mc_wdata,
    output logic        mc_msb,
    output logic        mc_lsb,
    input  logic        mc_ack,
    input  logic [15:0] mc_rdata,

    output logic        busy,
    output logic        grant,
    output logic        fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Last WAIT count before the access is declared dead; unused when TIMEOUT is 0.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
    localparam bit              TO_EN   = (TIMEOUT != 0);

    state_t          state;
    logic            last;
    logic [TO_W-1:0] to_cnt;
    logic            pick;

    // Winner selection: a lone requester always wins; ties go to p0 in fixed mode, else to the port not served last.
    always_comb begin
        pick = 1'b0;
        if (p0_req && p1_req) begin
            pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last;
        end else begin
            pick = p1_req;
        end
    end

    assign busy = (state != IDLE) && (state != FAULT);

    // Arbitration FSM with registered controller and port outputs.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            last     <= 1'b1;
            to_cnt   <= '0;
            mc_req   <= 1'b0;
            mc_write <= 1'b0;
            mc_addr  <= '0;
            mc_wdata <= '0;
            mc_msb   <= 1'b0;
            mc_lsb   <= 1'b0;
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= '0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
            grant    <= 1'b0;
            fault    <= 1'b0;
        end else begin
            mc_req <= 1'b0;
            p0_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_ack <= 1'b0;
            p1_err <= 1'b0;
            case (state)
                IDLE, FAULT: begin
                    if (p0_req || p1_req) begin
                        grant    <= pick;
                        mc_write <= pick ? p1_write : p0_write;
                        mc_addr  <= pick ? p1_addr  : p0_addr;
                        mc_wdata <= pick ? p1_wdata : p0_wdata;
                        mc_msb   <= pick ? p1_msb   : p0_msb;
                        mc_lsb   <= pick ? p1_lsb   : p0_lsb;
                        // Once faulted the controller is never poked again.
                        mc_req   <= (state == IDLE);
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    if (fault) begin
                        // Faulted path: answer immediately with an error and no data.
                        if (grant) begin
                            p1_ack   <= 1'b1;
                            p1_err   <= 1'b1;
                            p1_rdata <= '0;
                        end else begin
                            p0_ack   <= 1'b1;
                            p0_err   <= 1'b1;
                            p0_rdata <= '0;
                        end
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mc_ack) begin
                        if (grant) begin
                            p1_ack   <= 1'b1;
                            p1_rdata <= mc_rdata;
                        end else begin
                            p0_ack   <= 1'b1;
                            p0_rdata <= mc_rdata;
                        end
                        state <= DONE;
                    end else if (TO_EN && (to_cnt == TO_LAST)) begin
                        fault <= 1'b1;
                        if (grant) begin
                            p1_ack   <= 1'b1;
                            p1_err   <= 1'b1;
                            p1_rdata <= '0;
                        end else begin
                            p0_ack   <= 1'b1;
                            p0_err   <= 1'b1;
                            p0_rdata <= '0;
                        end
                        state <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    last  <= grant;
                    state <= fault ? FAULT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
